// File: rtl/fpmul_round_pack_pkg.sv
// Shared types for the FP multiply writeback stage: rounding modes, fflags
// bit positions, binary32 constants and the pipeline control bundle.
package fpmul_round_pack_pkg;

  localparam int ADDR_WIDTH = 5;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100,
    RM_DYN = 3'b111
  } rm_e;

  localparam int FFLAG_NX = 0;
  localparam int FFLAG_UF = 1;
  localparam int FFLAG_OF = 2;
  localparam int FFLAG_DZ = 3;
  localparam int FFLAG_NV = 4;

  localparam logic [31:0] FP32_CANON_NAN  = 32'h7FC0_0000;
  localparam logic [31:0] FP32_MAX_FINITE = 32'h7F7F_FFFF;
  localparam logic [31:0] FP32_POS_INF    = 32'h7F80_0000;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] rd;
    logic                  reg_write;
    logic                  FP_reg_write;
    logic [2:0]            wb_sel;
    logic [31:0]           pc;
  } exe_p_mux_bus_type;

  typedef struct packed {
    logic              valid;
    logic              sign;
    logic [9:0]        exp;
    logic [22:0]       frac;
    logic              is_nan;
    logic              is_inf;
    logic              is_zero;
    logic              nv;
    rm_e               rm;
    logic              inc;
    logic              inexact;
    exe_p_mux_bus_type pipe;
  } stage_a_t;

  typedef struct packed {
    logic              valid;
    logic [31:0]       result;
    logic [4:0]        fflags;
    exe_p_mux_bus_type pipe;
  } stage_b_t;

  // Dynamic mode picks the CSR value; any encoding left unresolved falls back to RNE.
  function automatic rm_e resolve_rm(input logic [2:0] rm, input logic [2:0] frm);
    logic [2:0] r;
    r = (rm == 3'b111) ? frm : rm;
    case (r)
      3'b000:  return RM_RNE;
      3'b001:  return RM_RTZ;
      3'b010:  return RM_RDN;
      3'b011:  return RM_RUP;
      3'b100:  return RM_RMM;
      default: return RM_RNE;
    endcase
  endfunction

endpackage

// File: rtl/fpmul_round_pack_if.sv
// Signal bundle around the round/pack stage; master drives operands, slave
// returns the packed result.
interface fpmul_round_pack_if;
  import fpmul_round_pack_pkg::*;

  logic              valid_i;
  logic              sign_i;
  logic [9:0]        exp_i;
  logic [46:0]       mant_i;
  logic              is_nan_i;
  logic              is_inf_i;
  logic              is_zero_i;
  logic              nv_i;
  logic [2:0]        rm_i;
  logic [2:0]        frm_i;
  exe_p_mux_bus_type pipe_i;
  exe_p_mux_bus_type pipe_o;
  logic              valid_o;
  logic [31:0]       result_o;
  logic [4:0]        fflags_o;

  // valid_i/valid_o qualify their bundles for one enabled cycle; there is no
  // ready, the stage advances on en and never back-pressures.
  modport master (
    output valid_i, sign_i, exp_i, mant_i, is_nan_i, is_inf_i, is_zero_i,
           nv_i, rm_i, frm_i, pipe_i,
    input  valid_o, result_o, fflags_o, pipe_o
  );

  modport slave (
    input  valid_i, sign_i, exp_i, mant_i, is_nan_i, is_inf_i, is_zero_i,
           nv_i, rm_i, frm_i, pipe_i,
    output valid_o, result_o, fflags_o, pipe_o
  );

endinterface

// File: rtl/fp_round_incr.sv
// Round-increment decision from rounding mode, sign and the LSB/G/R/S bits.
// Shared by the FP packers.
module fp_round_incr
  import fpmul_round_pack_pkg::*;
(
  input  rm_e  rm,
  input  logic sign,
  input  logic lsb,
  input  logic g,
  input  logic r,
  input  logic s,
  output logic inc,
  output logic inexact
);

  always_comb begin
    inexact = g | r | s;
    inc     = 1'b0;
    case (rm)
      RM_RNE:  inc = g & (r | s | lsb);
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign & inexact;
      RM_RUP:  inc = ~sign & inexact;
      RM_RMM:  inc = g;
      default: inc = g & (r | s | lsb);
    endcase
  end

endmodule

// File: rtl/fpmul_round_pack.sv
// Final FP multiply stage: stage A latches operands and the round decision,
// stage B applies the increment, resolves overflow/specials and packs binary32.
module fpmul_round_pack
  import fpmul_round_pack_pkg::*;
#(
  parameter int addr_width = 5,
  parameter int num_rds    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [num_rds-1:0]    clear,
  input  logic                  valid_i,
  input  logic                  sign_i,
  input  logic [9:0]            exp_i,
  input  logic [46:0]           mant_i,
  input  logic                  is_nan_i,
  input  logic                  is_inf_i,
  input  logic                  is_zero_i,
  input  logic                  nv_i,
  input  logic [2:0]            rm_i,
  input  logic [2:0]            frm_i,
  input  exe_p_mux_bus_type     pipe_i,
  output exe_p_mux_bus_type     pipe_o,
  output logic                  valid_o,
  output logic [31:0]           result_o,
  output logic [4:0]            fflags_o,
  output logic [addr_width-1:0] uu_rd [num_rds],
  output logic [num_rds-1:0]    uu_reg_write,
  output logic [num_rds-1:0]    uu_FP_reg_write
);

  stage_a_t stage_a_d, stage_a_q;
  stage_b_t stage_b_d, stage_b_q;

  rm_e  rm_eff;
  logic inc_a;
  logic inexact_a;

  assign rm_eff = resolve_rm(rm_i, frm_i);

  fp_round_incr u_round_incr (
    .rm      (rm_eff),
    .sign    (sign_i),
    .lsb     (mant_i[24]),
    .g       (mant_i[23]),
    .r       (mant_i[22]),
    .s       (|mant_i[21:0]),
    .inc     (inc_a),
    .inexact (inexact_a)
  );

  always_comb begin
    stage_a_d = stage_a_q;
    if (clear[num_rds-1]) begin
      stage_a_d = '0;
    end else if (en) begin
      stage_a_d.valid   = valid_i;
      stage_a_d.sign    = sign_i;
      stage_a_d.exp     = exp_i;
      stage_a_d.frac    = mant_i[46:24];
      stage_a_d.is_nan  = is_nan_i;
      stage_a_d.is_inf  = is_inf_i;
      stage_a_d.is_zero = is_zero_i;
      stage_a_d.nv      = nv_i;
      stage_a_d.rm      = rm_eff;
      stage_a_d.inc     = inc_a;
      stage_a_d.inexact = inexact_a;
      stage_a_d.pipe    = pipe_i;
    end
  end

  logic [31:0] sum;
  logic        ovf;
  logic [31:0] res_num;
  logic [4:0]  flags_num;
  logic [31:0] res_b;
  logic [4:0]  flags_b;

  // The fraction carry ripples into the exponent field, so subnormal->normal
  // and normal->overflow both fall out of one add; bit 31 catches a wrap past 0xFF.
  always_comb begin
    sum       = {1'b0, stage_a_q.exp[7:0], stage_a_q.frac} + {31'b0, stage_a_q.inc};
    ovf       = (!stage_a_q.exp[9] && (stage_a_q.exp >= 10'd255)) || (sum[31:23] >= 9'd255);
    res_num   = {stage_a_q.sign, sum[30:0]};
    flags_num = '0;
    if (ovf) begin
      flags_num[FFLAG_OF] = 1'b1;
      flags_num[FFLAG_NX] = 1'b1;
      case (stage_a_q.rm)
        RM_RTZ:  res_num = {stage_a_q.sign, FP32_MAX_FINITE[30:0]};
        RM_RDN:  res_num = stage_a_q.sign ? {1'b1, FP32_POS_INF[30:0]}
                                          : {1'b0, FP32_MAX_FINITE[30:0]};
        RM_RUP:  res_num = stage_a_q.sign ? {1'b1, FP32_MAX_FINITE[30:0]}
                                          : {1'b0, FP32_POS_INF[30:0]};
        default: res_num = {stage_a_q.sign, FP32_POS_INF[30:0]};
      endcase
    end else begin
      flags_num[FFLAG_NX] = stage_a_q.inexact;
      flags_num[FFLAG_UF] = stage_a_q.inexact && (sum[30:23] == 8'h00);
    end
  end

  always_comb begin
    res_b   = res_num;
    flags_b = flags_num;
    if (stage_a_q.is_nan) begin
      res_b             = FP32_CANON_NAN;
      flags_b           = '0;
      flags_b[FFLAG_NV] = stage_a_q.nv;
    end else if (stage_a_q.is_inf) begin
      res_b   = {stage_a_q.sign, FP32_POS_INF[30:0]};
      flags_b = '0;
    end else if (stage_a_q.is_zero) begin
      res_b   = {stage_a_q.sign, 31'b0};
      flags_b = '0;
    end
  end

  always_comb begin
    stage_b_d = stage_b_q;
    if (clear[0]) begin
      stage_b_d = '0;
    end else if (en) begin
      stage_b_d.valid  = stage_a_q.valid;
      stage_b_d.result = res_b;
      stage_b_d.fflags = flags_b;
      stage_b_d.pipe   = stage_a_q.pipe;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_a_q <= '0;
      stage_b_q <= '0;
    end else begin
      stage_a_q <= stage_a_d;
      stage_b_q <= stage_b_d;
    end
  end

  assign valid_o  = stage_b_q.valid;
  assign result_o = stage_b_q.result;
  assign fflags_o = stage_b_q.fflags;
  assign pipe_o   = stage_b_q.pipe;

  // Hazard view: uu_rd is indexed A-first, the bit vectors put stage A on the MSB.
  always_comb begin
    for (int i = 0; i < num_rds; i++) begin
      uu_rd[i] = '0;
    end
    uu_reg_write    = '0;
    uu_FP_reg_write = '0;
    uu_rd[0]                 = addr_width'(stage_a_q.pipe.rd);
    uu_rd[num_rds-1]         = addr_width'(stage_b_q.pipe.rd);
    uu_reg_write[num_rds-1]  = stage_a_q.pipe.reg_write;
    uu_reg_write[0]          = stage_b_q.pipe.reg_write;
    uu_FP_reg_write[num_rds-1] = stage_a_q.pipe.FP_reg_write;
    uu_FP_reg_write[0]       = stage_b_q.pipe.FP_reg_write;
  end

endmodule

// File: tb/tb_fpmul_round_pack.sv
// Randomised bench for fpmul_round_pack against a value-level rounding model
// carried through a two-slot transaction pipeline.
module tb_fpmul_round_pack;
  import fpmul_round_pack_pkg::*;

  localparam int AW = 5;
  localparam int NR = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [NR-1:0] clear;
  logic [AW-1:0] uu_rd [NR];
  logic [NR-1:0] uu_reg_write;
  logic [NR-1:0] uu_FP_reg_write;

  fpmul_round_pack_if bus ();

  always #5 clk = ~clk;

  fpmul_round_pack #(.addr_width(AW), .num_rds(NR)) dut (
    .clk             (clk),
    .rst             (rst),
    .en              (en),
    .clear           (clear),
    .valid_i         (bus.valid_i),
    .sign_i          (bus.sign_i),
    .exp_i           (bus.exp_i),
    .mant_i          (bus.mant_i),
    .is_nan_i        (bus.is_nan_i),
    .is_inf_i        (bus.is_inf_i),
    .is_zero_i       (bus.is_zero_i),
    .nv_i            (bus.nv_i),
    .rm_i            (bus.rm_i),
    .frm_i           (bus.frm_i),
    .pipe_i          (bus.pipe_i),
    .pipe_o          (bus.pipe_o),
    .valid_o         (bus.valid_o),
    .result_o        (bus.result_o),
    .fflags_o        (bus.fflags_o),
    .uu_rd           (uu_rd),
    .uu_reg_write    (uu_reg_write),
    .uu_FP_reg_write (uu_FP_reg_write)
  );

  int checks = 0;
  int errors = 0;
  logic checking = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Value-level reference: decide rounding from the discarded remainder against
  // one half ulp, then detect overflow on the rounded magnitude. Returns {fflags, result}.
  function automatic logic [36:0] ref_fp(input logic sign, input logic [9:0] e,
                                         input logic [46:0] m, input logic nan,
                                         input logic inf, input logic zero, input logic nv,
                                         input logic [2:0] rm, input logic [2:0] frm);
    int     mode;
    longint rem, mag;
    logic   up, nx, ovf, to_inf;
    mode = (rm == 3'd7) ? int'(frm) : int'(rm);
    if (mode > 4) mode = 0;
    if (nan)  return {nv, 4'b0, 32'h7FC0_0000};
    if (inf)  return {5'b0, sign, 8'hFF, 23'h0};
    if (zero) return {5'b0, sign, 31'h0};
    rem = longint'(m[23:0]);
    nx  = (rem != 0);
    case (mode)
      0:       up = (rem > 64'h80_0000) || ((rem == 64'h80_0000) && m[24]);
      1:       up = 1'b0;
      2:       up = sign && nx;
      3:       up = !sign && nx;
      default: up = (rem >= 64'h80_0000);
    endcase
    mag = longint'(e[7:0]) * 64'd8388608 + longint'(m[46:24]) + longint'(up);
    ovf = ($signed(e) >= 255) || (mag >= 64'd2139095040);
    if (ovf) begin
      to_inf = (mode == 0) || (mode == 4) || ((mode == 2) && sign) || ((mode == 3) && !sign);
      return {5'b00101, sign, to_inf ? 31'h7F80_0000 : 31'h7F7F_FFFF};
    end
    return {3'b000, nx && (mag < 64'd8388608), nx, sign, mag[30:0]};
  endfunction

  typedef struct packed {
    logic              valid;
    logic [4:0]        flags;
    logic [31:0]       res;
    exe_p_mux_bus_type pipe;
  } slot_t;

  slot_t ma, mb;

  always @(posedge clk) begin
    if (rst) begin
      ma <= '0;
      mb <= '0;
    end else begin
      if (clear[0]) mb <= '0;
      else if (en)  mb <= ma;
      if (clear[1]) ma <= '0;
      else if (en)  ma <= {bus.valid_i,
                           ref_fp(bus.sign_i, bus.exp_i, bus.mant_i, bus.is_nan_i,
                                  bus.is_inf_i, bus.is_zero_i, bus.nv_i, bus.rm_i, bus.frm_i),
                           bus.pipe_i};
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("valid_o", 64'(bus.valid_o), 64'(mb.valid));
      check("result_o", 64'(bus.result_o), 64'(mb.res));
      check("fflags_o", 64'(bus.fflags_o), 64'(mb.flags));
      check("pipe_o", 64'(bus.pipe_o), 64'(mb.pipe));
      check("uu_rd_a", 64'(uu_rd[0]), 64'(ma.pipe.rd));
      check("uu_rd_b", 64'(uu_rd[1]), 64'(mb.pipe.rd));
      check("uu_reg_write", 64'(uu_reg_write), 64'({ma.pipe.reg_write, mb.pipe.reg_write}));
      check("uu_FP_reg_write", 64'(uu_FP_reg_write),
            64'({ma.pipe.FP_reg_write, mb.pipe.FP_reg_write}));
    end
  end

  task automatic cycle();
    @(negedge clk);
  endtask

  task automatic rand_pipe();
    bus.pipe_i.rd           = 5'($urandom_range(0, 31));
    bus.pipe_i.reg_write    = 1'($urandom_range(0, 1));
    bus.pipe_i.FP_reg_write = 1'($urandom_range(0, 1));
    bus.pipe_i.wb_sel       = 3'($urandom_range(0, 7));
    bus.pipe_i.pc           = $urandom();
  endtask

  task automatic set_op(input logic sign, input logic [9:0] e, input logic [46:0] m,
                        input logic nan, input logic inf, input logic zero, input logic nv,
                        input logic [2:0] rm, input logic [2:0] frm);
    bus.valid_i   = 1'b1;
    bus.sign_i    = sign;
    bus.exp_i     = e;
    bus.mant_i    = m;
    bus.is_nan_i  = nan;
    bus.is_inf_i  = inf;
    bus.is_zero_i = zero;
    bus.nv_i      = nv;
    bus.rm_i      = rm;
    bus.frm_i     = frm;
    rand_pipe();
  endtask

  task automatic set_idle();
    bus.valid_i   = 1'b0;
    bus.is_nan_i  = 1'b0;
    bus.is_inf_i  = 1'b0;
    bus.is_zero_i = 1'b0;
    rand_pipe();
  endtask

  task automatic rand_op();
    logic [63:0] r64;
    logic [46:0] m;
    logic [9:0]  e;
    r64 = {$urandom(), $urandom()};
    m   = r64[46:0];
    if ($urandom_range(0, 3) == 0) m[23:0] = 24'h80_0000;
    if ($urandom_range(0, 7) == 0) m[46:24] = 23'h7F_FFFF;
    e = 10'($urandom_range(0, 260));
    if ($urandom_range(0, 5) == 0) e = 10'($urandom_range(0, 1));
    set_op(1'($urandom_range(0, 1)), e, m,
           $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
  endtask

  // Pins the reference against a hand-worked value, then streams the op into the DUT.
  task automatic pin(input string name, input logic sign, input logic [9:0] e,
                     input logic [46:0] m, input logic nan, input logic inf,
                     input logic zero, input logic nv, input logic [2:0] rm,
                     input logic [2:0] frm, input logic [31:0] er, input logic [4:0] ef);
    check(name, 64'(ref_fp(sign, e, m, nan, inf, zero, nv, rm, frm)), 64'({ef, er}));
    set_op(sign, e, m, nan, inf, zero, nv, rm, frm);
    cycle();
  endtask

  initial begin
    rst   = 1'b1;
    en    = 1'b0;
    clear = '0;
    bus.sign_i = 1'b0; bus.exp_i = '0; bus.mant_i = '0; bus.nv_i = 1'b0;
    bus.rm_i = '0; bus.frm_i = '0;
    set_idle();
    @(posedge clk);
    #1 checking = 1'b1;
    cycle();
    check("reset_valid", 64'(bus.valid_o), 64'd0);
    check("reset_result", 64'(bus.result_o), 64'd0);
    check("reset_fflags", 64'(bus.fflags_o), 64'd0);
    check("reset_pipe", 64'(bus.pipe_o), 64'd0);
    rst = 1'b0;
    en  = 1'b1;

    pin("rne_tie_odd",  0, 10'd127, {23'h000001, 24'h800000}, 0, 0, 0, 0, 3'd0, 3'd0, 32'h3F80_0002, 5'b00001);
    pin("rne_tie_even", 0, 10'd127, {23'h000000, 24'h800000}, 0, 0, 0, 0, 3'd0, 3'd0, 32'h3F80_0000, 5'b00001);
    pin("frac_carry",   0, 10'd126, {23'h7FFFFF, 24'hC00000}, 0, 0, 0, 0, 3'd0, 3'd0, 32'h3F80_0000, 5'b00001);
    pin("ovf_rtz",      0, 10'd255, 47'd0, 0, 0, 0, 0, 3'd1, 3'd0, 32'h7F7F_FFFF, 5'b00101);
    pin("ovf_rne",      0, 10'd255, 47'd0, 0, 0, 0, 0, 3'd0, 3'd0, 32'h7F80_0000, 5'b00101);
    pin("ovf_rup_neg",  1, 10'd255, 47'd0, 0, 0, 0, 0, 3'd3, 3'd0, 32'hFF7F_FFFF, 5'b00101);
    pin("ovf_rdn_neg",  1, 10'd255, 47'd0, 0, 0, 0, 0, 3'd2, 3'd0, 32'hFF80_0000, 5'b00101);
    pin("uf_rup",       0, 10'd0, 47'd1, 0, 0, 0, 0, 3'd3, 3'd0, 32'h0000_0001, 5'b00011);
    pin("uf_rne",       0, 10'd0, 47'd1, 0, 0, 0, 0, 3'd0, 3'd0, 32'h0000_0000, 5'b00011);
    pin("uf_dyn_rup",   0, 10'd0, 47'd1, 0, 0, 0, 0, 3'd7, 3'd3, 32'h0000_0001, 5'b00011);
    pin("rmm_tie",      0, 10'd127, {23'h000000, 24'h800000}, 0, 0, 0, 0, 3'd4, 3'd0, 32'h3F80_0001, 5'b00001);
    pin("rdn_neg",      1, 10'd127, {23'h000000, 24'h000001}, 0, 0, 0, 0, 3'd2, 3'd0, 32'hBF80_0001, 5'b00001);
    pin("rsvd_rm_rne",  0, 10'd127, {23'h000001, 24'h800000}, 0, 0, 0, 0, 3'd5, 3'd0, 32'h3F80_0002, 5'b00001);
    pin("nan_nv",       0, 10'd5, 47'd7, 1, 0, 0, 1, 3'd0, 3'd0, 32'h7FC0_0000, 5'b10000);
    pin("inf_neg",      1, 10'd255, 47'd7, 0, 1, 0, 0, 3'd0, 3'd0, 32'hFF80_0000, 5'b00000);
    pin("zero_neg",     1, 10'd0, 47'd7, 0, 0, 1, 0, 3'd0, 3'd0, 32'h8000_0000, 5'b00000);
    set_idle();
    repeat (3) cycle();

    // en low for one cycle in the middle of a stream
    rand_op(); cycle();
    rand_op(); en = 1'b0; cycle();
    en = 1'b1; cycle();
    rand_op(); cycle();
    set_idle(); repeat (2) cycle();

    // clear[0] drops the op sitting in stage B
    rand_op(); cycle();
    set_idle(); clear = 2'b01; cycle();
    check("clear_b_valid", 64'(bus.valid_o), 64'd0);
    clear = 2'b00; cycle();

    // clear[1] with en: stage B still captures the pre-flush stage A
    rand_op(); cycle();
    rand_op(); clear = 2'b10; cycle();
    clear = 2'b00; set_idle(); cycle();
    check("clear_a_valid", 64'(bus.valid_o), 64'd0);

    // rst mid-stream
    rand_op(); cycle();
    rand_op(); rst = 1'b1; cycle();
    check("rst_mid_valid", 64'(bus.valid_o), 64'd0);
    check("rst_mid_result", 64'(bus.result_o), 64'd0);
    check("rst_mid_fflags", 64'(bus.fflags_o), 64'd0);
    check("rst_mid_pipe", 64'(bus.pipe_o), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 4) == 0) set_idle();
      else rand_op();
      en       = ($urandom_range(0, 9) != 0);
      clear[1] = ($urandom_range(0, 19) == 0);
      clear[0] = ($urandom_range(0, 19) == 0);
      rst      = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 1'b0; en = 1'b1; clear = '0; set_idle();
    repeat (3) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
